// File: rtl/nios_system_sysid_pkg.sv
// Shared definitions for the system ID consistency checker.
// Holds the FSM state encoding, the sysid word addresses, the default expected
// words and the pass-verdict helper used by the checker top.
package nios_system_sysid_pkg;

  // FSM state encoding (kept as plain constants for legacy tool flows)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD_ID  = 2'd1;
  localparam logic [1:0] ST_RD_TS  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  // Word addresses inside the system ID peripheral
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Default expected contents of the two words
  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1371240070;

  // A check passes only if both words matched and no read was aborted.
  function automatic logic check_passed(input logic id_match,
                                        input logic ts_match,
                                        input logic timed_out);
    return id_match & ts_match & ~timed_out;
  endfunction

endpackage

// File: rtl/nios_system_sysid_checker_timeout.sv
// Avalon-MM read stall tracker, reusable by any checker that issues reads.
// Ports:
//   clock, reset     : clock and asynchronous active-high reset
//   clear            : zero the stall counter (new read about to start)
//   read, waitrequest: current bus handshake signals
//   complete         : read finishes this cycle (read=1, waitrequest=0)
//   expired          : read has already stalled TIMEOUT_CYCLES cycles and is
//                      still stalled, so the master must abandon it now
module avalon_read_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic read,
  input  logic waitrequest,
  output logic complete,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] count_q;
  logic [15:0] count_d;
  logic        stalled;

  assign stalled  = read & waitrequest;
  assign complete = read & ~waitrequest;
  assign expired  = stalled & (count_q == LIMIT);

  // Next stall count: cleared on request, saturates at the limit so it can never wrap
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 16'd0;
    end else if (stalled && (count_q != LIMIT)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nios_system_sysid_checker.sv
// Boot-time hardware/software consistency check against the sysid peripheral.
// Reads word 0 (system ID) and word 1 (build timestamp) over Avalon-MM and
// compares them with EXPECTED_ID / EXPECTED_TIMESTAMP.
// Ports:
//   clock, reset          : clock and asynchronous active-high reset
//   start                 : one-cycle request, ignored while busy
//   address, read         : registered Avalon master request (address=0 when idle)
//   waitrequest, readdata : Avalon slave response
//   busy                  : check in progress
//   done                  : one-cycle pulse at the end of every check
//   pass, id_ok, ts_ok    : verdict and per-word match flags of the last check
//   timeout               : last check aborted by a stalled read
//   id_value, ts_value    : words captured by the last check (0 if not read)
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  logic [1:0]  state_q,    state_d;
  logic        read_q,     read_d;
  logic        address_q,  address_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic        pass_q,     pass_d;
  logic        id_ok_q,    id_ok_d;
  logic        ts_ok_q,    ts_ok_d;
  logic        timeout_q,  timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  // Pending automatic check; loaded from AUTO_START by reset so the first
  // post-reset cycle behaves like a start request.
  logic        auto_q,     auto_d;

  logic        rd_complete;
  logic        rd_expired;
  logic        cnt_clear;
  logic        word_match;

  avalon_read_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock       (clock),
    .reset       (reset),
    .clear       (cnt_clear),
    .read        (read_q),
    .waitrequest (waitrequest),
    .complete    (rd_complete),
    .expired     (rd_expired)
  );

  // Compare the incoming word against the value expected at the current address
  always_comb begin
    word_match = 1'b0;
    if (address_q == SYSID_ADDR_TS) begin
      word_match = (readdata == EXPECTED_TIMESTAMP);
    end else begin
      word_match = (readdata == EXPECTED_ID);
    end
  end

  // Check sequencer: next state, bus request and status updates
  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    address_d  = address_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    auto_d     = auto_q;
    cnt_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start || auto_q) begin
          state_d    = ST_RD_ID;
          read_d     = 1'b1;
          address_d  = SYSID_ADDR_ID;
          pass_d     = 1'b0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = 32'd0;
          ts_value_d = 32'd0;
          auto_d     = 1'b0;
          cnt_clear  = 1'b1;
        end else begin
          read_d    = 1'b0;
          address_d = SYSID_ADDR_ID;
        end
      end

      ST_RD_ID: begin
        if (rd_complete) begin
          id_value_d = readdata;
          id_ok_d    = word_match;
          cnt_clear  = 1'b1;
          address_d  = SYSID_ADDR_TS;
          state_d    = ST_RD_TS;
        end else if (rd_expired) begin
          read_d    = 1'b0;
          address_d = SYSID_ADDR_ID;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_FINISH;
        end else begin
          state_d = ST_RD_ID;
        end
      end

      ST_RD_TS: begin
        if (rd_complete) begin
          ts_value_d = readdata;
          ts_ok_d    = word_match;
          pass_d     = check_passed(id_ok_q, word_match, timeout_q);
          read_d     = 1'b0;
          address_d  = SYSID_ADDR_ID;
          done_d     = 1'b1;
          state_d    = ST_FINISH;
        end else if (rd_expired) begin
          read_d    = 1'b0;
          address_d = SYSID_ADDR_ID;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_FINISH;
        end else begin
          state_d = ST_RD_TS;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        read_d    = 1'b0;
        address_d = SYSID_ADDR_ID;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      read_q     <= 1'b0;
      address_q  <= SYSID_ADDR_ID;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      auto_q     <= AUTO_START;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      address_q  <= address_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      auto_q     <= auto_d;
    end
  end

  assign read     = read_q;
  assign address  = address_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign id_ok    = id_ok_q;
  assign ts_ok    = ts_ok_q;
  assign timeout  = timeout_q;
  assign id_value = id_value_q;
  assign ts_value = ts_value_q;

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Scoreboard bench for nios_system_sysid_checker.
// Instance A: default parameters (auto start, 1024-cycle timeout).
// Instance B: AUTO_START=0, TIMEOUT_CYCLES=8.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] TS = 32'd1371240070;

  typedef struct {
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a;
  exp_t e_b;

  // Instance A signals
  logic        rst_a, start_a, wr_a;
  logic [31:0] id_a, ts_a;
  logic        address_a, read_a, busy_a, done_a, pass_a, id_ok_a, ts_ok_a, timeout_a;
  logic [31:0] readdata_a, id_value_a, ts_value_a;
  // Instance B signals
  logic        rst_b, start_b, wr_b;
  logic [31:0] id_b, ts_b;
  logic        address_b, read_b, busy_b, done_b, pass_b, id_ok_b, ts_ok_b, timeout_b;
  logic [31:0] readdata_b, id_value_b, ts_value_b;

  // Slave models: word selected by address
  assign readdata_a = address_a ? ts_a : id_a;
  assign readdata_b = address_b ? ts_b : id_b;

  nios_system_sysid_checker u_a (
    .clock(clk), .reset(rst_a), .start(start_a), .address(address_a), .read(read_a),
    .waitrequest(wr_a), .readdata(readdata_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .id_ok(id_ok_a), .ts_ok(ts_ok_a), .timeout(timeout_a),
    .id_value(id_value_a), .ts_value(ts_value_a)
  );

  nios_system_sysid_checker #(
    .TIMEOUT_CYCLES(8), .AUTO_START(1'b0)
  ) u_b (
    .clock(clk), .reset(rst_b), .start(start_b), .address(address_b), .read(read_b),
    .waitrequest(wr_b), .readdata(readdata_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .id_ok(id_ok_b), .ts_ok(ts_ok_b), .timeout(timeout_b),
    .id_value(id_value_b), .ts_value(ts_value_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic io, input logic tso, input logic to,
                              input logic [31:0] iv, input logic [31:0] tv, input int c);
    exp_t e;
    e.pass = p; e.id_ok = io; e.ts_ok = tso; e.tmo = to; e.idv = iv; e.tsv = tv; e.cyc = c;
    return e;
  endfunction

  task automatic chk_res(input string tag, input exp_t e, input logic b, input logic p,
                         input logic io, input logic tso, input logic to,
                         input logic [31:0] iv, input logic [31:0] tv);
    chk({tag, "_done_cycle"}, cyc, e.cyc);
    chk({tag, "_busy"},    32'(b),   32'd1);
    chk({tag, "_pass"},    32'(p),   32'(e.pass));
    chk({tag, "_id_ok"},   32'(io),  32'(e.id_ok));
    chk({tag, "_ts_ok"},   32'(tso), 32'(e.ts_ok));
    chk({tag, "_timeout"}, 32'(to),  32'(e.tmo));
    chk({tag, "_id_value"}, iv, e.idv);
    chk({tag, "_ts_value"}, tv, e.tsv);
  endtask

  // Monitor A: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst_a && done_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_done: got done=1 expected no check pending (cycle %0d)", cyc);
      end else begin
        e_a = q_a.pop_front();
        chk_res("a", e_a, busy_a, pass_a, id_ok_a, ts_ok_a, timeout_a, id_value_a, ts_value_a);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!rst_b && done_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_done: got done=1 expected no check pending (cycle %0d)", cyc);
      end else begin
        e_b = q_b.pop_front();
        chk_res("b", e_b, busy_b, pass_b, id_ok_b, ts_ok_b, timeout_b, id_value_b, ts_value_b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Wait (bounded) until the chosen scoreboard queue is empty
  task automatic drain(input bit use_b, input string tag);
    for (int i = 0; i < 40; i++) begin
      if ((use_b ? q_b.size() : q_a.size()) == 0) break;
      tick();
    end
    chk(tag, use_b ? q_b.size() : q_a.size(), 32'd0);
  endtask

  task automatic chk_zero(input string tag, input logic r, input logic a, input logic b,
                          input logic d, input logic p, input logic io, input logic tso,
                          input logic to, input logic [31:0] iv, input logic [31:0] tv);
    chk({tag, "_read"},    32'(r),   32'd0);
    chk({tag, "_address"}, 32'(a),   32'd0);
    chk({tag, "_busy"},    32'(b),   32'd0);
    chk({tag, "_done"},    32'(d),   32'd0);
    chk({tag, "_pass"},    32'(p),   32'd0);
    chk({tag, "_id_ok"},   32'(io),  32'd0);
    chk({tag, "_ts_ok"},   32'(tso), 32'd0);
    chk({tag, "_timeout"}, 32'(to),  32'd0);
    chk({tag, "_id_value"}, iv, 32'd0);
    chk({tag, "_ts_value"}, tv, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    wr_a = 1'b0; wr_b = 1'b0;
    id_a = 32'd0; ts_a = TS; id_b = 32'd0; ts_b = TS;
    repeat (3) tick();

    // Reset values
    chk_zero("rst_a", read_a, address_a, busy_a, done_a, pass_a, id_ok_a, ts_ok_a,
             timeout_a, id_value_a, ts_value_a);
    chk_zero("rst_b", read_b, address_b, busy_b, done_b, pass_b, id_ok_b, ts_ok_b,
             timeout_b, id_value_b, ts_value_b);

    // Automatic check after reset release, no stalls: done in cycle 3
    c0 = cyc;
    q_a.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, c0 + 3));
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    chk("auto_read",    32'(read_a),    32'd1);
    chk("auto_address", 32'(address_a), 32'd0);
    drain(1'b0, "auto_done_seen");
    tick();
    chk("auto_idle_busy", 32'(busy_a), 32'd0);
    chk("auto_pass_held", 32'(pass_a), 32'd1);
    chk("b_no_autostart", 32'(busy_b), 32'd0);

    // Five stalls on each read: done 10 cycles later, address stable while stalled
    c0 = cyc;
    start_a = 1'b1;
    q_a.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, c0 + 13));
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      wr_a = (k != 6) && (k != 12);
      chk($sformatf("stall_read_k%0d", k), 32'(read_a), 32'd1);
      chk($sformatf("stall_addr_k%0d", k), 32'(address_a), (k >= 7) ? 32'd1 : 32'd0);
      tick();
    end
    wr_a = 1'b0;
    drain(1'b0, "stall_done_seen");
    tick();

    // Wrong ID; start during RD_TS is dropped; next start clears flags on entry
    id_a = 32'h0000_0001;
    c0 = cyc;
    start_a = 1'b1;
    q_a.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0001, TS, c0 + 3));
    tick();
    start_a = 1'b0;
    tick();
    chk("rdts_address", 32'(address_a), 32'd1);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    chk("dropped_start_busy", 32'(busy_a), 32'd0);
    chk("badid_value_held",   id_value_a, 32'h0000_0001);
    id_a = 32'd0;
    c0 = cyc;
    start_a = 1'b1;
    q_a.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, c0 + 3));
    tick();
    start_a = 1'b0;
    chk("entry_id_value", id_value_a, 32'd0);
    chk("entry_ts_value", ts_value_a, 32'd0);
    chk("entry_ts_ok",    32'(ts_ok_a), 32'd0);
    chk("entry_pass",     32'(pass_a),  32'd0);
    drain(1'b0, "rerun_done_seen");

    // Instance B: timestamp read stalls forever, TIMEOUT_CYCLES=8
    ts_b = 32'hDEAD_BEEF;
    c0 = cyc;
    start_b = 1'b1;
    q_b.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, c0 + 11));
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      wr_b = (k != 1);
      if (k >= 2) chk($sformatf("tmo_addr_k%0d", k), 32'(address_b), 32'd1);
      if (k == 9) chk("tmo_read_8th_stall", 32'(read_b), 32'd1);
      tick();
    end
    chk("tmo_read_dropped", 32'(read_b), 32'd0);
    drain(1'b1, "tmo_done_seen");
    wr_b = 1'b0;
    ts_b = TS;
    tick();

    // Instance B: reset during a stalled ID read, then stays idle without start
    wr_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("pre_reset_read", 32'(read_b), 32'd1);
    chk("pre_reset_busy", 32'(busy_b), 32'd1);
    #2 rst_b = 1'b1;
    #1;
    chk_zero("midrst_b", read_b, address_b, busy_b, done_b, pass_b, id_ok_b, ts_ok_b,
             timeout_b, id_value_b, ts_value_b);
    @(negedge clk);
    rst_b = 1'b0;
    wr_b = 1'b0;
    repeat (6) tick();
    chk("post_reset_idle_busy", 32'(busy_b), 32'd0);
    chk("post_reset_idle_read", 32'(read_b), 32'd0);
    c0 = cyc;
    start_b = 1'b1;
    q_b.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS, c0 + 3));
    tick();
    start_b = 1'b0;
    drain(1'b1, "b_rerun_done_seen");
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
